// File: rtl/hack_rom_loader.sv
// Serial Hack program loader: parses SYNC/LEN/data/CHK frames from the UART,
// writes big-endian words into instruction ROM and gates the CPU reset.
module hack_rom_loader #(
  parameter int          ADDR_W         = 15,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter bit          BOOT_HOLD      = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rom_we,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic [15:0]       o_rom_data,
  output logic              o_cpu_reset,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int          TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] CAP = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK} state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d, len_new;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              timeout, fail, last_word;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      hi_q      <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cpu_rst_q <= BOOT_HOLD;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hi_d      = hi_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    cpu_rst_d = cpu_rst_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    fail      = 1'b0;
    len_new   = {len_q[15:8], i_rx_data};
    last_word = (32'(idx_q) + 32'd1) == 32'(len_q);

    // Idle-gap counter: only runs inside a frame, restarts on every byte.
    if (state_q == IDLE || i_rx_valid) tmo_d = '0;
    else                               tmo_d = tmo_q + TW'(1);
    timeout = (state_q != IDLE) && !i_rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    if (timeout) begin
      fail = 1'b1;
    end else if (i_rx_valid) begin
      case (state_q)
        IDLE: begin
          if (i_rx_data == SYNC_BYTE) begin
            state_d   = LEN_HI;
            busy_d    = 1'b1;
            cpu_rst_d = 1'b1;
            err_d     = 1'b0;
            sum_d     = '0;
            idx_d     = '0;
          end
        end
        LEN_HI: begin
          len_d   = {i_rx_data, 8'h00};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d = len_new;
          if (len_new == 16'd0 || 32'(len_new) > CAP) fail = 1'b1;
          else                                         state_d = DATA_HI;
        end
        DATA_HI: begin
          hi_d    = i_rx_data;
          sum_d   = sum_q + i_rx_data;
          state_d = DATA_LO;
        end
        DATA_LO: begin
          sum_d   = sum_q + i_rx_data;
          we_d    = 1'b1;
          addr_d  = idx_q;
          data_d  = {hi_q, i_rx_data};
          idx_d   = idx_q + ADDR_W'(1);
          state_d = last_word ? CHECK : DATA_HI;
        end
        CHECK: begin
          if (i_rx_data == sum_q) begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            cpu_rst_d = 1'b0;
            state_d   = IDLE;
          end else begin
            fail = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (fail) begin
      err_d   = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
    end
  end

  assign o_rom_we    = we_q;
  assign o_rom_addr  = addr_q;
  assign o_rom_data  = data_q;
  assign o_cpu_reset = cpu_rst_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Scoreboard bench for hack_rom_loader: frames are built from word lists, the
// expected ROM writes and done pulses are queued, and a monitor consumes them.
module tb_hack_rom_loader;

  localparam int         AW   = 15;
  localparam int         TMO  = 50;
  localparam bit         BH   = 1'b1;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          cpu_reset, busy, done, err;

  hack_rom_loader #(
    .ADDR_W(AW), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO), .BOOT_HOLD(BH)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rom_we(rom_we), .o_rom_addr(rom_addr), .o_rom_data(rom_data),
    .o_cpu_reset(cpu_reset), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [15:0] cur_words[$];
  int          pending_done = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: consumes expected writes and done pulses as the DUT presents them.
  initial begin
    logic prev_done;
    wr_t  e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rom_we) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write_addr", 32'(rom_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_wr.pop_front();
          check("write_addr", 32'(rom_addr), 32'(e.addr));
          check("write_data", 32'(rom_data), 32'(e.data));
        end
      end
      if (done) begin
        check("done_single_cycle", 32'(prev_done), 32'd0);
        check("done_expected", 32'(pending_done > 0), 32'd1);
        if (pending_done > 0) pending_done--;
      end
      prev_done = done;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic logic [7:0] frame_sum();
    int s = 0;
    foreach (cur_words[i]) s += int'(cur_words[i][15:8]) + int'(cur_words[i][7:0]);
    return 8'(s % 256);
  endfunction

  // Reference: word i lands at address i; done only if the checksum matches.
  task automatic send_frame(input bit bad, input string tag);
    logic [7:0] chk;
    int         n;
    n   = cur_words.size();
    chk = frame_sum() + (bad ? 8'd1 : 8'd0);
    foreach (cur_words[i]) exp_wr.push_back('{addr: AW'(i), data: cur_words[i]});
    if (!bad) pending_done++;
    send_byte(SYNC, $urandom_range(0, 4));
    check({tag, "_busy_after_sync"}, 32'(busy), 32'd1);
    send_byte(8'(n >> 8), $urandom_range(0, 4));
    send_byte(8'(n), $urandom_range(0, 4));
    foreach (cur_words[i]) begin
      send_byte(cur_words[i][15:8], $urandom_range(0, 4));
      send_byte(cur_words[i][7:0], $urandom_range(0, 4));
    end
    send_byte(chk, 3);
    check({tag, "_err"}, 32'(err), 32'(bad));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(bad));
    check({tag, "_writes_drained"}, 32'(exp_wr.size()), 32'd0);
    check({tag, "_done_drained"}, 32'(pending_done), 32'd0);
  endtask

  initial begin
    logic [7:0] tail[$];
    logic [7:0] c;
    repeat (3) @(negedge clk);
    check("rst_we", 32'(rom_we), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_data", 32'(rom_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'(BH));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    cur_words = '{16'h3039, 16'hEC10};
    send_frame(1'b0, "two_words");
    send_frame(1'b1, "bad_chk");
    cur_words = '{16'h1234};
    send_frame(1'b0, "clears_err");

    send_byte(SYNC, 2); send_byte(8'h00, 2); send_byte(8'h00, 3);
    check("zero_len_err", 32'(err), 32'd1);
    check("zero_len_busy", 32'(busy), 32'd0);
    send_byte(SYNC, 2); send_byte(8'h80, 2); send_byte(8'h01, 3);
    check("over_len_err", 32'(err), 32'd1);
    check("over_len_busy", 32'(busy), 32'd0);
    check("over_len_cpu_reset", 32'(cpu_reset), 32'd1);

    send_byte(8'h00, 1); send_byte(8'hFF, 1); send_byte(8'h12, 1);
    check("junk_ignored_busy", 32'(busy), 32'd0);
    cur_words = '{16'hABCD};
    send_frame(1'b0, "after_junk");

    send_byte(SYNC, 1); send_byte(8'h00, 1); send_byte(8'h01, 1); send_byte(8'hAB, 0);
    repeat (44) @(negedge clk);
    check("pre_timeout_err", 32'(err), 32'd0);
    check("pre_timeout_busy", 32'(busy), 32'd1);
    repeat (16) @(negedge clk);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_cpu_reset", 32'(cpu_reset), 32'd1);

    // Reset between hi and lo of word 1; only word 0 may be written.
    cur_words = '{};
    for (int i = 0; i < 3; i++) cur_words.push_back(16'($urandom) & 16'h7F7F);
    exp_wr.push_back('{addr: '0, data: cur_words[0]});
    send_byte(SYNC, 1); send_byte(8'h00, 1); send_byte(8'h03, 1);
    send_byte(cur_words[0][15:8], 1); send_byte(cur_words[0][7:0], 1);
    send_byte(cur_words[1][15:8], 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_we", 32'(rom_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'(BH));
    check("midrst_data", 32'(rom_data), 32'd0);
    check("midrst_writes_drained", 32'(exp_wr.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    c = frame_sum();
    if (c == SYNC) c = 8'h00;
    tail = '{cur_words[1][7:0], cur_words[2][15:8], cur_words[2][7:0], c};
    foreach (tail[i]) send_byte(tail[i], 1);
    repeat (3) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_err", 32'(err), 32'd0);

    for (int f = 0; f < 8; f++) begin
      cur_words = '{};
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) w[15:8] = SYNC;
        cur_words.push_back(w);
      end
      send_frame($urandom_range(0, 3) == 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
